inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue_if.sv | 33 +++
 rtl/inst_fetch_queue.sv | 120 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus bundle: redirect request, i$ request/return channel and decode-side head port.
// master is the fetch queue itself; slave is the i$/decode/redirect environment.
interface inst_fetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ibus_addr;
  logic        ibus_read;
  logic        ibus_flush_1;
  logic        ibus_flush_2;
  logic        ibus_flush_3;
  logic        ibus_stall;
  logic        ibus_ready;
  logic [31:0] ibus_rddata;
  logic        ibus_rddata_vld;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    input  redirect, redirect_pc, ibus_stall, ibus_ready, ibus_rddata, ibus_rddata_vld,
           inst_ready,
    output ibus_addr, ibus_read, ibus_flush_1, ibus_flush_2, ibus_flush_3, inst_valid, inst,
           inst_pc
  );

  modport slave (
    output redirect, redirect_pc, ibus_stall, ibus_ready, ibus_rddata, ibus_rddata_vld,
           inst_ready,
    input  ibus_addr, ibus_read, ibus_flush_1, ibus_flush_2, ibus_flush_3, inst_valid, inst,
           inst_pc
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: pre-allocates a slot per i$ request so in-order returns always fit,
// and presents the oldest returned instruction to decode.
module inst_fetch_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [31:0] BOOT_ADDR = 32'hbfc00000
) (
  input logic                clk,
  input logic                rst_n,
  inst_fetch_queue_if.master bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] alloc_q, alloc_d;
  logic [CW-1:0] alloc_cnt_q, alloc_cnt_d;
  logic [CW-1:0] fill_cnt_q, fill_cnt_d;
  logic          started_q;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] data_mem [DEPTH];

  logic issue_ok;
  logic flush;
  logic head_valid;
  logic accept;
  logic has_unfilled;
  logic fill_en;
  logic pop;

  always_comb begin
    // started_q keeps ibus_read and the strobes low until the first edge after reset release.
    issue_ok          = started_q && bus.ibus_ready && (alloc_cnt_q < FullCnt);
    bus.ibus_read     = issue_ok && !bus.redirect;
    bus.ibus_addr     = pc_q;
    flush             = started_q && bus.redirect;
    bus.ibus_flush_1  = flush;
    bus.ibus_flush_2  = flush;
    bus.ibus_flush_3  = flush;
    head_valid        = (fill_cnt_q != '0);
    bus.inst_valid    = head_valid;
    bus.inst          = data_mem[head_q];
    bus.inst_pc       = pc_mem[head_q];

    accept       = issue_ok && !bus.redirect && !bus.ibus_stall;
    has_unfilled = (alloc_cnt_q != fill_cnt_q);
    fill_en      = bus.ibus_rddata_vld && !bus.redirect && has_unfilled;
    pop          = head_valid && bus.inst_ready && !bus.redirect;

    pc_d        = pc_q;
    head_d      = head_q;
    fill_d      = fill_q;
    alloc_d     = alloc_q;
    alloc_cnt_d = alloc_cnt_q;
    fill_cnt_d  = fill_cnt_q;

    if (bus.redirect) begin
      pc_d        = bus.redirect_pc;
      head_d      = '0;
      fill_d      = '0;
      alloc_d     = '0;
      alloc_cnt_d = '0;
      fill_cnt_d  = '0;
    end else begin
      if (accept) begin
        alloc_d = alloc_q + PW'(1);
        pc_d    = pc_q + 32'd4;
      end
      if (fill_en) begin
        fill_d = fill_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      alloc_cnt_d = alloc_cnt_q + CW'(accept) - CW'(pop);
      fill_cnt_d  = fill_cnt_q + CW'(fill_en) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= BOOT_ADDR;
      head_q      <= '0;
      fill_q      <= '0;
      alloc_q     <= '0;
      alloc_cnt_q <= '0;
      fill_cnt_q  <= '0;
      started_q   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      head_q      <= head_d;
      fill_q      <= fill_d;
      alloc_q     <= alloc_d;
      alloc_cnt_q <= alloc_cnt_d;
      fill_cnt_q  <= fill_cnt_d;
      started_q   <= 1'b1;
    end
  end

  // Entry storage needs no reset; only slots between head and fill are ever read as valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_mem[alloc_q] <= pc_q;
    end
    if (fill_en) begin
      data_mem[fill_q] <= bus.ibus_rddata;
    end
  end

`ifndef SYNTHESIS
  spurious_return_a: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.ibus_rddata_vld && !bus.redirect) |-> has_unfilled)
    else $error("ibus_rddata_vld with no outstanding request");
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue: an i$ model with variable in-order latency and a
// queue-level reference of expected fetch/decode behaviour.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH     = 8;
  localparam logic [31:0] BOOT_ADDR = 32'hbfc00000;

  logic clk;
  logic rst_n;
  inst_fetch_queue_if bus ();

  inst_fetch_queue #(
    .DEPTH     (DEPTH),
    .BOOT_ADDR (BOOT_ADDR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] idata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  // Reference: entries allocated but not popped (oldest first), how many of them are filled.
  logic [31:0] ent_pc[$];
  int          nfilled;
  logic [31:0] model_pc;
  bit          started;
  req_t        pend[$];
  int          cyc;

  int          p_ready  = 100;
  int          p_stall  = 0;
  int          p_iready = 100;
  int          p_redir  = 0;
  int          lat_lo   = 2;
  int          lat_hi   = 2;
  bit          force_redir = 0;
  logic [31:0] force_pc;

  int          obs_acc = 0;
  int          obs_pop = 0;
  logic [31:0] obs_pop_pc;
  logic [31:0] obs_addr;
  bit          obs_valid;
  logic [31:0] pop_log[$];
  bit          wrap_pending = 0;
  bit          wrap_seen = 0;

  task automatic model_clear();
    ent_pc.delete();
    pend.delete();
    nfilled      = 0;
    model_pc     = BOOT_ADDR;
    started      = 0;
    wrap_pending = 0;
  endtask

  task automatic cycle();
    bit          rdy, stl, ird, rdr, vld;
    bit          exp_read, exp_valid, acc, pop, fil;
    logic [31:0] rpc, rdata;
    int          lat;
    rdy   = ($urandom_range(99) < p_ready);
    stl   = ($urandom_range(99) < p_stall);
    ird   = ($urandom_range(99) < p_iready);
    rdr   = force_redir || (started && ($urandom_range(99) < p_redir));
    rpc   = force_redir ? force_pc : ($urandom & 32'hffff_fffc);
    force_redir = 0;
    vld   = 1'b0;
    rdata = $urandom;
    if (rdr) begin
      pend.delete();
      vld = $urandom_range(1);
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      vld   = 1'b1;
      rdata = idata(pend[0].addr);
      void'(pend.pop_front());
    end
    bus.ibus_ready      = rdy;
    bus.ibus_stall      = stl;
    bus.inst_ready      = ird;
    bus.redirect        = rdr;
    bus.redirect_pc     = rpc;
    bus.ibus_rddata_vld = vld;
    bus.ibus_rddata     = rdata;

    @(negedge clk);
    exp_read  = started && rdy && (ent_pc.size() < DEPTH) && !rdr;
    exp_valid = (nfilled > 0);
    check_eq("ibus_read", bus.ibus_read, exp_read);
    if (exp_read) check_eq("ibus_addr", bus.ibus_addr, model_pc);
    if (wrap_pending && !rdr) begin
      check_eq("wrap_addr", bus.ibus_addr, 32'h0);
      wrap_seen = 1;
    end
    wrap_pending = 0;
    check_eq("flush", {bus.ibus_flush_1, bus.ibus_flush_2, bus.ibus_flush_3},
             (rdr && started) ? 3'b111 : 3'b000);
    check_eq("inst_valid", bus.inst_valid, exp_valid);
    if (exp_valid) begin
      check_eq("inst_pc", bus.inst_pc, ent_pc[0]);
      check_eq("inst", bus.inst, idata(ent_pc[0]));
    end
    obs_addr  = bus.ibus_addr;
    obs_valid = bus.inst_valid;
    if (bus.ibus_read && !stl) obs_acc++;
    if (bus.inst_valid && ird && !rdr) begin
      obs_pop++;
      obs_pop_pc = bus.inst_pc;
    end
    acc = exp_read && !stl;
    pop = exp_valid && ird && !rdr;
    fil = vld && !rdr && (nfilled < ent_pc.size());

    @(posedge clk);
    #1;
    cyc++;
    if (rdr) begin
      ent_pc.delete();
      nfilled  = 0;
      model_pc = rpc;
    end else begin
      if (acc) begin
        lat = $urandom_range(lat_hi, lat_lo);
        ent_pc.push_back(model_pc);
        pend.push_back('{addr: model_pc, due: cyc - 1 + lat});
        if (model_pc == 32'hffff_fffc) wrap_pending = 1;
        model_pc = model_pc + 32'd4;
      end
      if (fil) nfilled++;
      if (pop) begin
        pop_log.push_back(ent_pc.pop_front());
        nfilled--;
      end
    end
    started = 1;
  endtask

  // Called just after a rising edge; asserts reset mid-cycle, independent of the clock.
  task automatic apply_reset();
    bus.ibus_ready = 1'b1;
    bus.redirect   = 1'b0;
    bus.inst_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_read", bus.ibus_read, 1'b0);
    check_eq("rst_valid", bus.inst_valid, 1'b0);
    check_eq("rst_flush", {bus.ibus_flush_1, bus.ibus_flush_2, bus.ibus_flush_3}, 3'b000);
    check_eq("rst_addr", bus.ibus_addr, BOOT_ADDR);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, pop0, n;
    logic [31:0] a0;
    rst_n               = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_pc     = '0;
    bus.ibus_stall      = 1'b0;
    bus.ibus_ready      = 1'b0;
    bus.ibus_rddata     = '0;
    bus.ibus_rddata_vld = 1'b0;
    bus.inst_ready      = 1'b0;
    cyc                 = 0;
    force_pc            = '0;
    obs_pop_pc          = '0;
    model_clear();
    @(posedge clk);
    #1;
    apply_reset();

    // i$ not ready for 16 cycles, then streaming fetch from BOOT_ADDR.
    p_ready = 0;
    repeat (16) cycle();
    check_eq("nready_acc", obs_acc, 0);
    p_ready = 100;
    pop_log.delete();
    repeat (12) cycle();
    check_eq("first_pc0", pop_log[0], 32'hbfc00000);
    check_eq("first_pc1", pop_log[1], 32'hbfc00004);
    check_eq("first_pc2", pop_log[2], 32'hbfc00008);
    pop0 = obs_pop;
    repeat (10) cycle();
    check_eq("one_per_cycle", obs_pop - pop0, 10);

    // Decode blocked: exactly DEPTH acceptances, then one more per popped entry.
    force_redir = 1;
    force_pc    = 32'h0000_1000;
    p_iready    = 0;
    cycle();
    acc0 = obs_acc;
    repeat (20) cycle();
    check_eq("full_acc", obs_acc - acc0, DEPTH);
    check_eq("full_read", bus.ibus_read, 1'b0);
    acc0 = obs_acc;
    p_iready = 100;
    cycle();
    p_iready = 0;
    repeat (10) cycle();
    check_eq("refill_acc", obs_acc - acc0, 1);

    // Five-cycle stall mid-stream holds the address.
    p_iready = 100;
    repeat (10) cycle();
    p_stall = 100;
    cycle();
    a0 = obs_addr;
    repeat (4) begin
      cycle();
      check_eq("stall_addr", obs_addr, a0);
    end
    p_stall = 0;
    repeat (12) cycle();

    // Redirect with three requests in flight.
    lat_lo      = 4;
    lat_hi      = 4;
    force_redir = 1;
    force_pc    = 32'h0000_2000;
    cycle();
    n = 0;
    while (pend.size() < 3 && n < 40) begin
      cycle();
      n++;
    end
    check_eq("inflight3", pend.size() >= 3, 1'b1);
    force_redir = 1;
    force_pc    = 32'h8000_1000;
    cycle();
    cycle();
    check_eq("post_redir_valid", obs_valid, 1'b0);
    pop0 = obs_pop;
    n    = 0;
    while (obs_pop == pop0 && n < 20) begin
      cycle();
      n++;
    end
    check_eq("redir_first_pc", obs_pop_pc, 32'h8000_1000);

    // Fetch PC wrap at 2^32 and pointer wrap over many pops.
    lat_lo      = 2;
    lat_hi      = 2;
    force_redir = 1;
    force_pc    = 32'hffff_fff0;
    cycle();
    pop0 = obs_pop;
    repeat (40) cycle();
    check_eq("wrap_seen", wrap_seen, 1'b1);
    check_eq("wrap_pops", (obs_pop - pop0) >= 2 * DEPTH, 1'b1);

    // Random traffic.
    p_ready  = 90;
    p_stall  = 25;
    p_iready = 60;
    p_redir  = 2;
    lat_lo   = 1;
    lat_hi   = 5;
    repeat (3000) cycle();

    // Reset in the middle of traffic, then restart from BOOT_ADDR.
    apply_reset();
    p_redir = 0;
    repeat (60) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
